// File: rtl/elevator_car_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_car_scheduler
//   Single-car SCAN scheduler. Latches hall and car calls into a pending
//   vector, moves the car one floor per TRAVEL_TICKS simulation ticks, holds
//   the door for DOOR_TICKS ticks and pulses `served` on door opening so the
//   people controller knows which floor's riders may board and alight.
//
// Ports
//   clk                 system clock
//   rst                 asynchronous active-low reset
//   sim_state   [1:0]   00 STOP, 01 RUN, 10/11 PAUSE
//   sim_speed   [2:0]   tick period = 2^(7-sim_speed) clk cycles
//   floors_requested    hall calls (level), OR'd into pending
//   floor_destinations  car calls (level), OR'd into pending
//   current_floor       car position
//   direction   [1:0]   00 idle, 01 up, 10 down (only non-zero while moving)
//   door_open           high while the door is open
//   pending             latched outstanding calls
//   served              one-hot, one-cycle pulse on door opening
//   sim_tick            prescaler strobe (debug)
// ---------------------------------------------------------------------------
module elevator_car_scheduler #(
    parameter int unsigned FLOORS       = 12,
    parameter int unsigned FLOOR_W      = 4,
    parameter int unsigned TRAVEL_TICKS = 4,
    parameter int unsigned DOOR_TICKS   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         sim_state,
    input  logic [2:0]         sim_speed,
    input  logic [FLOORS-1:0]  floors_requested,
    input  logic [FLOORS-1:0]  floor_destinations,
    output logic [FLOOR_W-1:0] current_floor,
    output logic [1:0]         direction,
    output logic               door_open,
    output logic [FLOORS-1:0]  pending,
    output logic [FLOORS-1:0]  served,
    output logic               sim_tick
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_DOOR
    } state_t;

    function automatic logic [FLOORS-1:0] f_onehot(input logic [FLOOR_W-1:0] f);
        logic [FLOORS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            v[i] = (32'(f) == i);
        end
        return v;
    endfunction

    function automatic logic f_above(input logic [FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0] f);
        logic a;
        a = 1'b0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (i > 32'(f)) a = a | p[i];
        end
        return a;
    endfunction

    function automatic logic f_below(input logic [FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0] f);
        logic b;
        b = 1'b0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (i < 32'(f)) b = b | p[i];
        end
        return b;
    endfunction

    // Registers
    state_t             r_state;
    logic [FLOOR_W-1:0] r_floor;
    logic [CNT_W-1:0]   r_travel_cnt;
    logic [CNT_W-1:0]   r_door_cnt;
    logic               r_last_up;
    logic [FLOORS-1:0]  r_pending;
    logic [FLOORS-1:0]  r_served;
    logic [6:0]         r_presc;

    // Next-state / combinational signals
    state_t             w_state_nxt;
    logic [FLOOR_W-1:0] w_floor_nxt;
    logic [CNT_W-1:0]   w_travel_nxt;
    logic [CNT_W-1:0]   w_door_nxt;
    logic               w_last_up_nxt;
    logic [FLOORS-1:0]  w_pending_nxt;
    logic [FLOORS-1:0]  w_served_nxt;
    logic [FLOORS-1:0]  w_clear_mask;
    logic [6:0]         w_presc_nxt;
    logic               w_to_door;
    logic               w_run;
    logic               w_stop;
    logic               w_tick;
    logic [7:0]         w_period;
    logic [6:0]         w_limit;
    logic               w_err;
    logic [FLOOR_W-1:0] w_floor_up;
    logic [FLOOR_W-1:0] w_floor_dn;

    assign w_run  = (sim_state == 2'b01);
    assign w_stop = (sim_state == 2'b00);

    // ">=" rather than "==" so lowering the period mid-count wraps at once.
    assign w_period = 8'd1 << (3'd7 - sim_speed);
    assign w_limit  = 7'(w_period - 8'd1);
    assign w_tick   = rst & w_run & (r_presc >= w_limit);

    assign w_floor_up = r_floor + FLOOR_W'(1);
    assign w_floor_dn = r_floor - FLOOR_W'(1);

    // Moving past either end shaft limit is unreachable when the SCAN
    // decisions are correct; if it ever happens the car parks in IDLE.
    assign w_err = ((r_state == S_MOVE_UP)   && (32'(r_floor) >= FLOORS - 1)) ||
                   ((r_state == S_MOVE_DOWN) && (r_floor == '0));

    always_comb begin
        w_state_nxt   = r_state;
        w_floor_nxt   = r_floor;
        w_travel_nxt  = r_travel_cnt;
        w_door_nxt    = r_door_cnt;
        w_last_up_nxt = r_last_up;
        w_presc_nxt   = r_presc;

        if (w_run) begin
            w_presc_nxt = w_tick ? '0 : r_presc + 7'd1;

            unique case (r_state)
                S_IDLE: begin
                    if (|(r_pending & f_onehot(r_floor))) begin
                        w_state_nxt = S_DOOR;
                        w_door_nxt  = '0;
                    end else if (f_above(r_pending, r_floor) &&
                                 f_below(r_pending, r_floor)) begin
                        w_state_nxt = r_last_up ? S_MOVE_UP : S_MOVE_DOWN;
                    end else if (f_above(r_pending, r_floor)) begin
                        w_state_nxt = S_MOVE_UP;
                    end else if (f_below(r_pending, r_floor)) begin
                        w_state_nxt = S_MOVE_DOWN;
                    end
                end

                S_MOVE_UP: begin
                    if (w_err) begin
                        w_state_nxt  = S_IDLE;
                        w_travel_nxt = '0;
                    end else if (w_tick) begin
                        if (r_travel_cnt == CNT_W'(TRAVEL_TICKS - 1)) begin
                            w_travel_nxt  = '0;
                            w_floor_nxt   = w_floor_up;
                            w_last_up_nxt = 1'b1;
                            if (|(r_pending & f_onehot(w_floor_up))) begin
                                w_state_nxt = S_DOOR;
                                w_door_nxt  = '0;
                            end else if (!f_above(r_pending, w_floor_up)) begin
                                w_state_nxt = S_IDLE;
                            end
                        end else begin
                            w_travel_nxt = r_travel_cnt + CNT_W'(1);
                        end
                    end
                end

                S_MOVE_DOWN: begin
                    if (w_err) begin
                        w_state_nxt  = S_IDLE;
                        w_travel_nxt = '0;
                    end else if (w_tick) begin
                        if (r_travel_cnt == CNT_W'(TRAVEL_TICKS - 1)) begin
                            w_travel_nxt  = '0;
                            w_floor_nxt   = w_floor_dn;
                            w_last_up_nxt = 1'b0;
                            if (|(r_pending & f_onehot(w_floor_dn))) begin
                                w_state_nxt = S_DOOR;
                                w_door_nxt  = '0;
                            end else if (!f_below(r_pending, w_floor_dn)) begin
                                w_state_nxt = S_IDLE;
                            end
                        end else begin
                            w_travel_nxt = r_travel_cnt + CNT_W'(1);
                        end
                    end
                end

                S_DOOR: begin
                    if (w_tick) begin
                        if (r_door_cnt == CNT_W'(DOOR_TICKS - 1)) begin
                            w_state_nxt = S_IDLE;
                            w_door_nxt  = '0;
                        end else begin
                            w_door_nxt = r_door_cnt + CNT_W'(1);
                        end
                    end
                end

                default: w_state_nxt = S_IDLE;
            endcase
        end

        w_to_door = (w_state_nxt == S_DOOR) && (r_state != S_DOOR);

        // On arrival the floor register updates on the same edge the door
        // opens, so the mask must use the floor being arrived at.
        if (r_state == S_DOOR) begin
            w_clear_mask = f_onehot(r_floor);
        end else if (w_to_door) begin
            w_clear_mask = f_onehot(w_floor_nxt);
        end else begin
            w_clear_mask = '0;
        end

        w_served_nxt  = w_to_door ? f_onehot(w_floor_nxt) : '0;
        w_pending_nxt = (r_pending | floors_requested | floor_destinations) &
                        ~w_clear_mask;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_floor      <= '0;
            r_travel_cnt <= '0;
            r_door_cnt   <= '0;
            r_last_up    <= 1'b1;
            r_pending    <= '0;
            r_served     <= '0;
            r_presc      <= '0;
        end else if (w_stop) begin
            r_state      <= S_IDLE;
            r_floor      <= '0;
            r_travel_cnt <= '0;
            r_door_cnt   <= '0;
            r_last_up    <= 1'b1;
            r_pending    <= '0;
            r_served     <= '0;
            r_presc      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_floor      <= w_floor_nxt;
            r_travel_cnt <= w_travel_nxt;
            r_door_cnt   <= w_door_nxt;
            r_last_up    <= w_last_up_nxt;
            r_pending    <= w_pending_nxt;
            r_served     <= w_served_nxt;
            r_presc      <= w_presc_nxt;
        end
    end

    assign current_floor = r_floor;
    assign direction     = (r_state == S_MOVE_UP)   ? 2'b01 :
                           (r_state == S_MOVE_DOWN) ? 2'b10 : 2'b00;
    assign door_open     = (r_state == S_DOOR);
    assign pending       = r_pending;
    assign served        = r_served;
    assign sim_tick      = w_tick;

endmodule
